mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : HI/LO multiply/divide unit for a MIPS-style pipeline.
//               MULT/MULTU finish in one cycle. DIV/DIVU use a radix-2
//               restoring divider on operand magnitudes, one quotient bit
//               per cycle. A zero divisor short-circuits the iterations.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,            // asynchronous, active low
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        stall_req,
  output logic        hilo_write_en,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // op[1] selects divide, op[0] selects unsigned
  localparam logic [31:0] c_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [4:0]  c_LAST_IT  = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sgn_q, sgn_d;      // 1 = signed operation (MULT / DIV)
  logic        div0_q, div0_d;    // divisor was zero at accept
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;      // iteration counter
  logic [31:0] quot_q, quot_d;    // shifting dividend / partial quotient
  logic [31:0] rem_q, rem_d;      // partial remainder
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        w_accept;
  logic [31:0] w_a_mag_in;
  logic [31:0] w_b_mag;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic        w_fits;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quot_nxt;
  logic        w_q_neg;
  logic        w_r_neg;
  logic [31:0] w_quot_fin;
  logic [31:0] w_rem_fin;
  logic signed [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [63:0] w_prod;

  // Accept only from IDLE and never in the same cycle as a flush
  assign w_accept = (state_q == S_IDLE) && start && !flush;

  // Dividend magnitude loaded straight into the shift register at accept;
  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign w_a_mag_in = (!op[0] && operand_a[31]) ? -operand_a : operand_a;
  assign w_b_mag    = (sgn_q && b_q[31]) ? -b_q : b_q;

  // One restoring-division step: shift in next dividend bit, trial subtract
  assign w_shift    = {rem_q, quot_q[31]};
  assign w_trial    = w_shift - {1'b0, w_b_mag};
  assign w_fits     = !w_trial[32];
  assign w_rem_nxt  = w_fits ? w_trial[31:0] : w_shift[31:0];
  assign w_quot_nxt = {quot_q[30:0], w_fits};

  // Sign fix-up: quotient negative on differing signs, remainder follows
  // the dividend; truncating division semantics
  assign w_q_neg    = sgn_q && (a_q[31] ^ b_q[31]);
  assign w_r_neg    = sgn_q && a_q[31];
  assign w_quot_fin = w_q_neg ? -w_quot_nxt : w_quot_nxt;
  assign w_rem_fin  = w_r_neg ? -w_rem_nxt : w_rem_nxt;

  // Full 64-bit products; signed one through sign-extended operands
  assign w_prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign w_prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign w_prod   = sgn_q ? $unsigned(w_prod_s) : w_prod_u;

  // Next-state and datapath update logic
  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    div0_d  = div0_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          sgn_d   = !op[0];
          div0_d  = (operand_b == 32'd0);
          a_d     = operand_a;
          b_d     = operand_b;
          cnt_d   = 5'd0;
          rem_d   = 32'd0;
          quot_d  = w_a_mag_in;
          state_d = op[1] ? S_DIV : S_MUL;
        end
      end

      S_MUL: begin
        hi_d    = w_prod[63:32];
        lo_d    = w_prod[31:0];
        state_d = S_DONE;
      end

      S_DIV: begin
        if (div0_q) begin
          hi_d    = a_q;
          lo_d    = c_ALL_ONES;
          state_d = S_DONE;
        end else begin
          rem_d  = w_rem_nxt;
          quot_d = w_quot_nxt;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == c_LAST_IT) begin
            hi_d    = w_rem_fin;
            lo_d    = w_quot_fin;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // start here belongs to the instruction just finished
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush aborts whatever is in flight without touching HI/LO
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      div0_q  <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      cnt_q   <= 5'd0;
      quot_q  <= 32'd0;
      rem_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      div0_q  <= div0_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall is held low while reset is asserted, even if start is high
  assign stall_req     = rst && (w_accept || (state_q == S_MUL) || (state_q == S_DIV));
  assign hilo_write_en = (state_q == S_DONE) && !flush;
  assign hi            = hi_q;
  assign lo            = lo_q;

endmodule
`default_nettype wire
